// File: rtl/sfifo_rd_stream.sv
// -----------------------------------------------------------------------------
// sfifo_rd_stream
//   Drain stage for the synchronous single-clock FIFO (normal, non-ahead mode).
//   Issues read enables, tracks reads still inside the FIFO RAM pipeline, and
//   lands the returned words in a small circular skid buffer. That buffer feeds
//   a valid/ready stream at one beat per cycle, hiding the FIFO read latency.
//
//   Optional feature macro: SFIFO_RD_STREAM_STAT_EN
//     defined   -> beat_cnt counts accepted beats (32-bit, wraps, reset only)
//     undefined -> beat_cnt tied to zero, no counter logic
//
// Parameters
//   DATA_WIDTH  width of FIFO read data and stream data
//   RD_LAT      cycles from fifo_ren to valid fifo_rdata (1 or 2)
//   BUF_DEPTH   skid buffer entries, >= RD_LAT+1 for full throughput (2..4)
//
// Ports
//   clk_sys     in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag (registered in the FIFO)
//   fifo_ren    out  FIFO read enable
//   fifo_rdata  in   FIFO read data, valid RD_LAT cycles after fifo_ren
//   m_valid     out  stream data valid
//   m_data      out  stream data
//   m_ready     in   consumer accepts the current beat
//   buf_cnt     out  words held in the skid buffer (reads in flight excluded)
//   beat_cnt    out  accepted-beat counter (optional feature)
// -----------------------------------------------------------------------------
module sfifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int BUF_DEPTH  = RD_LAT + 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [2:0]            buf_cnt,
  output logic [31:0]           beat_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LAST_PTR = ptr_t'(BUF_DEPTH - 1);

  logic [RD_LAT-1:0]     infl_sr_q, infl_sr_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic [2:0]            buf_cnt_q, buf_cnt_d;

  logic       pop;
  logic       wr_en;
  logic [3:0] infl;
  logic [3:0] occ_after_pop;

  // Reads still travelling through the FIFO RAM pipeline.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + 4'(infl_sr_q[i]);
    end
  end

  assign m_valid = (buf_cnt_q != 3'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign buf_cnt = buf_cnt_q;
  assign pop     = m_valid & m_ready;

  // A read whose marker sits in the last stage has its data on fifo_rdata now.
  assign wr_en = infl_sr_q[RD_LAT-1];

  // Every issued read owns a buffer slot from the moment it is issued, so the
  // buffer can never overflow. Crediting this cycle's pop is what allows a
  // read every cycle while the consumer keeps up.
  assign occ_after_pop = 4'(buf_cnt_q) + infl - 4'(pop);
  assign fifo_ren      = ~reset & ~fifo_empty & (occ_after_pop < 4'(BUF_DEPTH));

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    infl_sr_d = '0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_cnt_d = buf_cnt_q;

    infl_sr_d[0] = fifo_ren;
    for (int i = 1; i < RD_LAT; i++) begin
      infl_sr_d[i] = infl_sr_q[i-1];
    end

    // Explicit wrap compare: BUF_DEPTH need not be a power of two.
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 3'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 3'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      infl_sr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      buf_cnt_q <= '0;
      // NOTE: the storage is reset as well because m_data is read straight
      // from it and must come out of reset as zero; it is only a few entries.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      infl_sr_q <= infl_sr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      buf_cnt_q <= buf_cnt_d;
      if (wr_en) begin
        buf_q[wr_ptr_q] <= fifo_rdata;
      end
    end
  end

`ifdef SFIFO_RD_STREAM_STAT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_sfifo_rd_stream
//   Two instances run side by side: u_dut1 with RD_LAT=1 and u_dut2 with
//   RD_LAT=2, each fed by its own behavioural FIFO model. One instance at a
//   time is selected and observed. Words loaded into a FIFO are also pushed
//   into a scoreboard queue, and every accepted beat pops and compares one.
// -----------------------------------------------------------------------------
module tb_sfifo_rd_stream;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        m_ready;

  logic        empty1, ren1, valid1;
  logic [7:0]  rdata1, data1;
  logic [2:0]  cnt1;
  logic [31:0] beat1;

  logic        empty2, ren2, valid2;
  logic [7:0]  rdata2, data2;
  logic [2:0]  cnt2;
  logic [31:0] beat2;

  sfifo_rd_stream #(.DATA_WIDTH(8), .RD_LAT(1)) u_dut1 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .fifo_empty(empty1),
    .fifo_ren  (ren1),
    .fifo_rdata(rdata1),
    .m_valid   (valid1),
    .m_data    (data1),
    .m_ready   (m_ready),
    .buf_cnt   (cnt1),
    .beat_cnt  (beat1)
  );

  sfifo_rd_stream #(.DATA_WIDTH(8), .RD_LAT(2)) u_dut2 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .fifo_empty(empty2),
    .fifo_ren  (ren2),
    .fifo_rdata(rdata2),
    .m_valid   (valid2),
    .m_data    (data2),
    .m_ready   (m_ready),
    .buf_cnt   (cnt2),
    .beat_cnt  (beat2)
  );

  // Selected instance (0: RD_LAT=1, 1: RD_LAT=2).
  logic        sel;
  logic        s_empty, s_ren, s_valid;
  logic [7:0]  s_data;
  logic [2:0]  s_cnt, s_depth;
  logic [31:0] s_beat;

  assign s_empty = sel ? empty2 : empty1;
  assign s_ren   = sel ? ren2   : ren1;
  assign s_valid = sel ? valid2 : valid1;
  assign s_data  = sel ? data2  : data1;
  assign s_cnt   = sel ? cnt2   : cnt1;
  assign s_beat  = sel ? beat2  : beat1;
  assign s_depth = sel ? 3'd3   : 3'd2;

  int          vectors;
  int          miscompares;
  logic [7:0]  fq1[$];
  logic [7:0]  fq2[$];
  logic [7:0]  sb[$];
  logic [7:0]  p2a;
  logic        prev_ren1, prev_ren2, prev_rst;
  logic        hold_q;
  logic [7:0]  hold_data;
  logic [31:0] exp_beat;

  // One clock cycle. At the falling edge the FIFO models apply the reads
  // accepted at the previous rising edge, then inputs are driven; outputs are
  // sampled 2 ns later, well before the next rising edge.
  task automatic tick(input logic rdy, input logic rst);
    logic [7:0] exp_w;
    logic       s_pop;
    @(negedge clk_sys);
    if (prev_rst) begin
      fq1.delete();
      fq2.delete();
      sb.delete();
    end else begin
      if (prev_ren1 && fq1.size() > 0) rdata1 = fq1.pop_front();
      rdata2 = p2a;
      if (prev_ren2 && fq2.size() > 0) p2a = fq2.pop_front();
    end
    empty1  = (fq1.size() == 0);
    empty2  = (fq2.size() == 0);
    m_ready = rdy;
    reset   = rst;
    #2;

    vectors++;
    if (s_cnt > s_depth) begin
      miscompares++;
      $display("FAIL buf_cnt_bound: got %0d, limit %0d", s_cnt, s_depth);
    end
    vectors++;
    if (s_ren && (s_empty || reset)) begin
      miscompares++;
      $display("FAIL ren_guard: fifo_ren=1 with fifo_empty=%0b reset=%0b", s_empty, reset);
    end
    if (hold_q) begin
      vectors++;
      if (s_valid !== 1'b1 || s_data !== hold_data) begin
        miscompares++;
        $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                 s_valid, s_data, hold_data);
      end
    end
    vectors++;
    if (s_beat !== exp_beat) begin
      miscompares++;
      $display("FAIL beat_cnt: got %08h, expected %08h", s_beat, exp_beat);
    end

    s_pop = s_valid & m_ready & ~reset;
    if (s_pop) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got %02h, expected no beat", s_data);
      end else begin
        exp_w = sb.pop_front();
        if (s_data !== exp_w) begin
          miscompares++;
          $display("FAIL beat_data: got %02h, expected %02h", s_data, exp_w);
        end
      end
    end

    hold_q    = s_valid & ~m_ready & ~reset;
    hold_data = s_data;
`ifdef SFIFO_RD_STREAM_STAT_EN
    if (reset) exp_beat = 32'd0;
    else if (s_pop) exp_beat = exp_beat + 32'd1;
`endif
    prev_ren1 = ren1;
    prev_ren2 = ren2;
    prev_rst  = reset;
  endtask

  task automatic do_reset(input logic which);
    tick(1'b0, 1'b1);
    sel = which;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic load(input int n, input logic [7:0] base, input logic rnd);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      if (sel) fq2.push_back(w);
      else     fq1.push_back(w);
      sb.push_back(w);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if (s_valid !== 1'b0 || s_data !== 8'h00 || s_cnt !== 3'd0 || s_ren !== 1'b0 || s_beat !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%0b data=%02h cnt=%0d ren=%0b beat=%0h, expected all zero",
               s_valid, s_data, s_cnt, s_ren, s_beat);
    end
    load(2, 8'hA0, 1'b0);
    tick(1'b0, 1'b0);
    vectors++;
    if (s_ren !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_ren: got %0b, expected 1", s_ren);
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (s_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_blocks_ren: got %0b, expected 0", s_ren);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_stream_lat1();
    int n_ren, n_beat, f_ren, l_ren, f_v, l_v;
    n_ren = 0; n_beat = 0; f_ren = -1; l_ren = -1; f_v = -1; l_v = -1;
    do_reset(1'b0);
    load(16, 8'h01, 1'b0);
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, 1'b0);
      if (s_ren) begin
        n_ren++;
        if (f_ren < 0) f_ren = c;
        l_ren = c;
      end
      if (s_valid) begin
        n_beat++;
        if (f_v < 0) f_v = c;
        l_v = c;
      end
    end
    vectors++;
    if (n_ren != 16 || l_ren - f_ren != 15) begin
      miscompares++;
      $display("FAIL lat1_ren_run: got %0d pulses over %0d cycles, expected 16 over 16", n_ren, l_ren - f_ren + 1);
    end
    vectors++;
    if (n_beat != 16 || l_v - f_v != 15) begin
      miscompares++;
      $display("FAIL lat1_beat_run: got %0d beats over %0d cycles, expected 16 over 16", n_beat, l_v - f_v + 1);
    end
    vectors++;
    if (f_ren < 0 || f_v - f_ren < 1 || f_v - f_ren > 2) begin
      miscompares++;
      $display("FAIL lat1_first_beat: got latency %0d, expected read latency window 1..2", f_v - f_ren);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL lat1_drained: got %0d words outstanding, expected 0", sb.size());
    end
`ifdef SFIFO_RD_STREAM_STAT_EN
    vectors++;
    if (s_beat !== 32'd16) begin
      miscompares++;
      $display("FAIL lat1_beat_cnt: got %0d, expected 16", s_beat);
    end
`endif
  endtask

  task automatic test_backpressure_lat2();
    int  n_ren, run;
    logic gap;
    n_ren = 0; run = 0; gap = 1'b0;
    do_reset(1'b1);
    load(8, 8'h20, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b0);
      if (s_ren) n_ren++;
    end
    vectors++;
    if (n_ren != 3) begin
      miscompares++;
      $display("FAIL bp_ren_pulses: got %0d, expected 3", n_ren);
    end
    vectors++;
    if (s_cnt !== 3'd3 || s_valid !== 1'b1 || s_data !== 8'h20) begin
      miscompares++;
      $display("FAIL bp_parked: got cnt=%0d valid=%0b data=%02h, expected cnt=3 valid=1 data=20",
               s_cnt, s_valid, s_data);
    end
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0);
      if (s_valid && !gap) run++;
      else gap = 1'b1;
    end
    vectors++;
    if (run != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain_run: got %0d consecutive beats (%0d left), expected 8 (0 left)", run, sb.size());
    end
  endtask

  task automatic test_toggle();
    int n_beat;
    logic [2:0] max_cnt;
    n_beat = 0; max_cnt = '0;
    do_reset(1'b1);
    load(20, 8'h00, 1'b1);
    for (int c = 0; c < 120; c++) begin
      tick((c % 2) == 0, 1'b0);
      if (s_valid && m_ready) n_beat++;
      if (s_cnt > max_cnt) max_cnt = s_cnt;
    end
    vectors++;
    if (n_beat != 20 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL toggle_count: got %0d beats (%0d left), expected 20 (0 left)", n_beat, sb.size());
    end
    vectors++;
    if (max_cnt > 3'd3) begin
      miscompares++;
      $display("FAIL toggle_max_cnt: got %0d, expected at most 3", max_cnt);
    end
  endtask

  task automatic test_single();
    int n_ren, n_beat;
    n_ren = 0; n_beat = 0;
    do_reset(1'b1);
    load(1, 8'h5A, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0);
      if (s_ren) n_ren++;
      if (s_valid) n_beat++;
    end
    vectors++;
    if (n_ren != 1 || n_beat != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL single_word: got ren=%0d beats=%0d left=%0d, expected 1 1 0", n_ren, n_beat, sb.size());
    end
    vectors++;
    if (s_ren !== 1'b0 || s_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle: got ren=%0b empty=%0b, expected ren=0 empty=1", s_ren, s_empty);
    end
  endtask

  task automatic test_reset_midflight();
    int n_ren, n_valid, c;
    n_ren = 0; n_valid = 0; c = 0;
    do_reset(1'b1);
    load(8, 8'h80, 1'b0);
    while (n_ren < 2 && c < 10) begin
      tick(1'b0, 1'b0);
      if (s_ren) n_ren++;
      c++;
    end
    vectors++;
    if (n_ren < 2) begin
      miscompares++;
      $display("FAIL midflight_ren_timeout: got %0d reads in 10 cycles, expected 2", n_ren);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    vectors++;
    if (s_valid !== 1'b0 || s_cnt !== 3'd0 || s_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_cleared: got valid=%0b cnt=%0d ren=%0b, expected 0 0 0", s_valid, s_cnt, s_ren);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0);
      if (s_valid) n_valid++;
    end
    vectors++;
    if (n_valid != 0) begin
      miscompares++;
      $display("FAIL midflight_stale: got %0d beats after reset, expected 0", n_valid);
    end
  endtask

  task automatic test_beat_wrap();
    do_reset(1'b1);
`ifdef SFIFO_RD_STREAM_STAT_EN
    force u_dut2.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut2.beat_cnt_q;
    exp_beat = 32'hFFFF_FFFE;
`endif
    load(3, 8'hC0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b0);
    end
`ifdef SFIFO_RD_STREAM_STAT_EN
    vectors++;
    if (s_beat !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL beat_wrap: got %08h, expected 00000001", s_beat);
    end
`else
    vectors++;
    if (s_beat !== 32'd0) begin
      miscompares++;
      $display("FAIL beat_tied: got %08h, expected 00000000", s_beat);
    end
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL beat_wrap_drained: got %0d words left, expected 0", sb.size());
    end
  endtask

  initial begin
    reset       = 1'b1;
    m_ready     = 1'b0;
    sel         = 1'b0;
    empty1      = 1'b1;
    empty2      = 1'b1;
    rdata1      = '0;
    rdata2      = '0;
    p2a         = '0;
    prev_ren1   = 1'b0;
    prev_ren2   = 1'b0;
    prev_rst    = 1'b1;
    hold_q      = 1'b0;
    hold_data   = '0;
    exp_beat    = '0;
    vectors     = 0;
    miscompares = 0;

    test_reset();
    test_stream_lat1();
    test_backpressure_lat2();
    test_toggle();
    test_single();
    test_reset_midflight();
    test_beat_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
